// File: rtl/fetch_unit_if.sv
// fetch_unit_if: byte-wide shared memory port between the fetch unit
// (master) and the memory (slave).
//   mem_addr  : request address (master -> slave)
//   mem_req   : request valid, held until mem_ack (master -> slave)
//   mem_we    : store strobe (master -> slave)
//   mem_wdata : store data (master -> slave)
//   mem_ack   : request completes this cycle (slave -> master)
//   mem_rdata : load data, valid with mem_ack (slave -> master)
interface fetch_unit_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_req;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic              mem_ack;
  logic [7:0]        mem_rdata;

  modport master (
    output mem_addr, mem_req, mem_we, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_addr, mem_req, mem_we, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch and memory sequencer.
// Holds the PC, fetches one byte-wide instruction per step over the shared
// memory port, presents it on instr and pulses exec for one cycle. In the
// exec cycle the controller may request a data load/store (performed on the
// same port before the next fetch) and/or a jump.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   bus        : memory port (fetch_unit_if.master)
//   instr      : instruction register
//   exec       : one-cycle pulse, instr is new
//   data_fetch, data_we, data_addr, data_wdata : data access request (EXEC only)
//   data_rdata : last loaded byte
//   data_done  : one-cycle pulse when a data access completes
//   jump, jump_addr : PC load request (EXEC only)
//   pc         : address of the next fetch
module fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  fetch_unit_if.master      bus,
  output logic [7:0]        instr,
  output logic              exec,
  input  logic              data_fetch,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [7:0]        data_wdata,
  output logic [7:0]        data_rdata,
  output logic              data_done,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic [ADDR_W-1:0] pc
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_DATA
  } state_t;

  state_t            state;
  state_t            state_nxt;

  // Data access captured in EXEC and replayed in DATA
  logic              cap_we;
  logic [ADDR_W-1:0] cap_addr;
  logic [7:0]        cap_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    bus.mem_req   = 1'b0;
    bus.mem_addr  = pc;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = 8'h00;
    exec          = 1'b0;
    data_done     = 1'b0;
    case (state)
      S_IDLE: begin
        state_nxt = S_FETCH;
      end
      S_FETCH: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ack) begin
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        exec      = 1'b1;
        state_nxt = data_fetch ? S_DATA : S_FETCH;
      end
      S_DATA: begin
        bus.mem_req   = 1'b1;
        bus.mem_addr  = cap_addr;
        bus.mem_we    = cap_we;
        bus.mem_wdata = cap_wdata;
        if (bus.mem_ack) begin
          data_done = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Architectural registers: PC, instruction, load result
  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      instr      <= 8'h00;
      data_rdata <= 8'h00;
      cap_we     <= 1'b0;
    end else begin
      if (state == S_FETCH && bus.mem_ack) begin
        instr <= bus.mem_rdata;
        pc    <= pc + 1'b1;
      end
      if (state == S_EXEC) begin
        cap_we <= data_we;
        // A jump replaces the increment already applied during FETCH
        if (jump) begin
          pc <= jump_addr;
        end
      end
      if (state == S_DATA && bus.mem_ack && !cap_we) begin
        data_rdata <= bus.mem_rdata;
      end
    end
  end

  // Address and store data only matter in DATA, so they carry no reset
  always_ff @(posedge clk) begin
    if (state == S_EXEC) begin
      cap_addr  <= data_addr;
      cap_wdata <= data_wdata;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam int ADDR_W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  // ---------------- main DUT (RESET_PC = 0) ----------------
  fetch_unit_if #(.ADDR_W(ADDR_W)) mif ();
  logic [7:0]        instr, data_rdata, data_wdata;
  logic              exec, data_done, data_fetch, data_we, jump;
  logic [ADDR_W-1:0] data_addr, jump_addr, pc;

  fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(16'h0000)) u_dut (
    .clk(clk), .rst(rst), .bus(mif),
    .instr(instr), .exec(exec),
    .data_fetch(data_fetch), .data_we(data_we), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_done(data_done),
    .jump(jump), .jump_addr(jump_addr), .pc(pc)
  );

  // Memory with a programmable number of wait cycles per request
  logic [7:0] mem [0:65535];
  int         wait_n;
  int         wcnt;
  assign mif.mem_ack   = mif.mem_req && (wcnt >= wait_n);
  assign mif.mem_rdata = mem[mif.mem_addr];
  always @(posedge clk) begin
    if (mif.mem_req && !mif.mem_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  // ---------------- second DUT (RESET_PC = 0xFFFF) ----------------
  fetch_unit_if #(.ADDR_W(ADDR_W)) mif2 ();
  logic [7:0]        instr2, data_rdata2;
  logic              exec2, data_done2;
  logic [ADDR_W-1:0] pc2;
  assign mif2.mem_ack   = mif2.mem_req;
  assign mif2.mem_rdata = mif2.mem_addr[7:0] ^ 8'h5A;

  fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(16'hFFFF)) u_dut2 (
    .clk(clk), .rst(rst), .bus(mif2),
    .instr(instr2), .exec(exec2),
    .data_fetch(1'b0), .data_we(1'b0), .data_addr(16'h0000),
    .data_wdata(8'h00), .data_rdata(data_rdata2), .data_done(data_done2),
    .jump(1'b0), .jump_addr(16'h0000), .pc(pc2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model + compare ----------------
  // Transaction view: next fetch address, the instruction that must be
  // presented, a pending data access, and the last loaded byte.
  logic [15:0] m_fetch;
  logic [7:0]  m_instr;
  logic [7:0]  m_rdata;
  logic        m_exec_due;
  logic        m_dpend;
  logic        m_dwe;
  logic [15:0] m_daddr;
  logic [7:0]  m_dwdata;
  logic        prev_stall;
  logic [15:0] prev_addr;

  always @(negedge clk) begin
    if (rst) begin
      m_fetch    = 16'h0000;
      m_instr    = 8'h00;
      m_rdata    = 8'h00;
      m_exec_due = 1'b0;
      m_dpend    = 1'b0;
      prev_stall = 1'b0;
    end else begin
      logic dpend_now;
      logic got_ack;
      dpend_now = m_dpend;
      got_ack   = 1'b0;
      chk("m_pc", pc, m_fetch);
      chk("m_exec", exec, m_exec_due);
      chk("m_data_rdata", data_rdata, m_rdata);
      if (exec) begin
        chk("m_instr", instr, m_instr);
        if (data_fetch) begin
          m_dpend  = 1'b1;
          m_dwe    = data_we;
          m_daddr  = data_addr;
          m_dwdata = data_wdata;
        end
        if (jump) m_fetch = jump_addr;
      end
      m_exec_due = 1'b0;
      if (exec) chk("m_no_req_in_exec", mif.mem_req, 1'b0);
      if (mif.mem_req) begin
        if (prev_stall) chk("m_addr_stable", mif.mem_addr, prev_addr);
        if (dpend_now) begin
          chk("m_daddr", mif.mem_addr, m_daddr);
          chk("m_dwe", mif.mem_we, m_dwe);
          chk("m_dwdata", mif.mem_wdata, m_dwdata);
        end else begin
          chk("m_faddr", mif.mem_addr, m_fetch);
          chk("m_fwe", mif.mem_we, 1'b0);
        end
        if (mif.mem_ack) begin
          got_ack = 1'b1;
          if (dpend_now) begin
            if (m_dwe) mem[mif.mem_addr] = mif.mem_wdata;
            else m_rdata = mem[m_daddr];
            m_dpend = 1'b0;
          end else begin
            m_instr    = mem[m_fetch];
            m_fetch    = m_fetch + 16'h1;
            m_exec_due = 1'b1;
          end
        end
      end
      chk("m_data_done", data_done, dpend_now && got_ack);
      prev_stall = mif.mem_req && !mif.mem_ack;
      prev_addr  = mif.mem_addr;
    end
  end

  // ---------------- directed sequence ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0000] = 8'h10;
    mem[16'h0001] = 8'h20;
    mem[16'h0002] = 8'h31;
    mem[16'h0003] = 8'h42;
    mem[16'h0004] = 8'h53;
    mem[16'h0100] = 8'h64;
    mem[16'h1234] = 8'hA5;
    mem[16'h2000] = 8'h77;
    rst = 1'b1; wait_n = 0;
    data_fetch = 0; data_we = 0; data_addr = '0; data_wdata = '0;
    jump = 0; jump_addr = '0;

    // Reset values
    cyc(); cyc();
    chk("rst_mem_req", mif.mem_req, 0);
    chk("rst_mem_addr", mif.mem_addr, 16'h0000);
    chk("rst_mem_we", mif.mem_we, 0);
    chk("rst_mem_wdata", mif.mem_wdata, 0);
    chk("rst_exec", exec, 0);
    chk("rst_instr", instr, 0);
    chk("rst_data_rdata", data_rdata, 0);
    chk("rst_data_done", data_done, 0);
    chk("rst_pc", pc, 16'h0000);
    chk("rst2_pc", pc2, 16'hFFFF);
    chk("rst2_mem_addr", mif2.mem_addr, 16'hFFFF);
    rst = 1'b0;

    // Zero-wait fetches of 0x10, 0x20; one instruction every 2 cycles
    cyc();
    chk("t1_first_req", mif.mem_req, 1);
    chk("t1_first_addr", mif.mem_addr, 16'h0000);
    chk("t5_first_addr", mif2.mem_addr, 16'hFFFF);
    cyc();
    chk("t1_exec0", exec, 1);
    chk("t1_instr0", instr, 8'h10);
    chk("t1_pc1", pc, 16'h0001);
    chk("t5_pc_wrap", pc2, 16'h0000);
    chk("t5_instr", instr2, 8'hA5);
    cyc();
    chk("t1_exec_low", exec, 0);
    chk("t1_addr1", mif.mem_addr, 16'h0001);
    chk("t5_addr_wrap", mif2.mem_addr, 16'h0000);
    chk("t5_req_wrap", mif2.mem_req, 1);
    cyc();
    chk("t1_exec1", exec, 1);
    chk("t1_instr1", instr, 8'h20);
    chk("t1_pc2", pc, 16'h0002);

    // Three wait cycles: request held 4 cycles, single exec
    wait_n = 3;
    cyc();
    for (int i = 0; i < 4; i++) begin
      chk("t2_req_held", mif.mem_req, 1);
      chk("t2_addr_held", mif.mem_addr, 16'h0002);
      chk("t2_no_exec", exec, 0);
      chk("t2_instr_held", instr, 8'h20);
      if (i < 3) cyc();
    end
    wait_n = 0;
    cyc();
    chk("t2_exec", exec, 1);
    chk("t2_instr", instr, 8'h31);
    cyc();
    chk("t2_single_exec", exec, 0);
    chk("t2_next_addr", mif.mem_addr, 16'h0003);

    // Load from 0x1234
    data_fetch = 1; data_we = 0; data_addr = 16'h1234;
    cyc();
    chk("t3_exec", exec, 1);
    cyc();
    data_fetch = 0; data_addr = '0;
    chk("t3_data_req", mif.mem_req, 1);
    chk("t3_data_addr", mif.mem_addr, 16'h1234);
    chk("t3_data_we", mif.mem_we, 0);
    chk("t3_data_done", data_done, 1);
    cyc();
    chk("t3_rdata", data_rdata, 8'hA5);
    chk("t3_done_low", data_done, 0);
    chk("t3_next_fetch", mif.mem_addr, 16'h0004);

    // Store 0x3C to 0x0040 with a jump to 0x0100
    data_fetch = 1; data_we = 1; data_addr = 16'h0040; data_wdata = 8'h3C;
    jump = 1; jump_addr = 16'h0100;
    cyc();
    chk("t4_exec", exec, 1);
    cyc();
    data_fetch = 0; data_we = 0; data_addr = '0; data_wdata = '0;
    jump = 0; jump_addr = '0;
    chk("t4_store_we", mif.mem_we, 1);
    chk("t4_store_wdata", mif.mem_wdata, 8'h3C);
    chk("t4_store_addr", mif.mem_addr, 16'h0040);
    chk("t4_pc_jump", pc, 16'h0100);
    cyc();
    chk("t4_rdata_kept", data_rdata, 8'hA5);
    chk("t4_fetch_target", mif.mem_addr, 16'h0100);
    chk("t4_mem_written", mem[16'h0040], 8'h3C);
    chk("t4_wdata_idle", mif.mem_wdata, 8'h00);

    // Reset during a stalled load
    data_fetch = 1; data_we = 0; data_addr = 16'h2000;
    cyc();
    chk("t6_exec", exec, 1);
    chk("t6_instr", instr, 8'h64);
    wait_n = 10;
    cyc();
    data_fetch = 0; data_addr = '0;
    chk("t6_stall_req", mif.mem_req, 1);
    chk("t6_stall_addr", mif.mem_addr, 16'h2000);
    cyc();
    chk("t6_stall_no_done", data_done, 0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    wait_n = 0;
    chk("t6_req_low", mif.mem_req, 0);
    chk("t6_no_done", data_done, 0);
    chk("t6_no_exec", exec, 0);
    chk("t6_instr_rst", instr, 8'h00);
    chk("t6_rdata_rst", data_rdata, 8'h00);
    chk("t6_pc_rst", pc, 16'h0000);
    chk("t6_addr_rst", mif.mem_addr, 16'h0000);
    cyc();
    chk("t6_restart_req", mif.mem_req, 1);
    chk("t6_restart_addr", mif.mem_addr, 16'h0000);
    cyc();
    chk("t6_restart_exec", exec, 1);
    chk("t6_restart_instr", instr, 8'h10);
    cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
